// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: address type, sizes and tag arithmetic.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] rf_addr_t;

  // Next allocation tag; wraps modulo 2^width.
  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned width);
    return (tag + 1) % (32'd1 << width);
  endfunction
endpackage

// File: rtl/rf_sb_entry.sv
// One scoreboard entry: busy bit and allocation tag for a single architectural register (never x0).
module rf_sb_entry
  import rf_pkg::*;
#(
  parameter int       TAG_WIDTH = 2,
  parameter int       NUM_WR    = 2,
  parameter rf_addr_t IDX       = 5'd1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        alloc_en,
  input  rf_addr_t                    alloc_addr,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*REG_ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*TAG_WIDTH-1:0] wr_tag,
  output logic                        busy,
  output logic [TAG_WIDTH-1:0]        tag,
  output logic [TAG_WIDTH-1:0]        next_tag
);
  logic                 busy_q, busy_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 alloc_hit;
  logic                 wb_clear;

  assign next_tag  = TAG_WIDTH'(tag_inc(32'(tag_q), TAG_WIDTH));
  assign alloc_hit = alloc_en & ~flush & (alloc_addr == IDX);

  // Any writeback carrying the current (pre-update) tag retires the allocation.
  always_comb begin
    wb_clear = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wr_addr[k*REG_ADDR_W +: REG_ADDR_W] == IDX) &&
          (wr_tag[k*TAG_WIDTH +: TAG_WIDTH] == tag_q)) begin
        wb_clear = 1'b1;
      end
    end
  end

  // Flush beats allocation, allocation beats a retiring writeback.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (alloc_hit) begin
      busy_d = 1'b1;
      tag_d  = next_tag;
    end else if (wb_clear) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign busy = busy_q;
  assign tag  = tag_q;
endmodule

// File: rtl/regfile_scoreboard_mp.sv
// Multi-port register file with busy/tag scoreboard, prioritised writeback ports and optional
// same-cycle write-to-read forwarding.
module regfile_scoreboard_mp
  import rf_pkg::*;
#(
  parameter int XLEN      = rf_pkg::XLEN,
  parameter int TAG_WIDTH = 2,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         alloc_en,
  input  rf_addr_t                     alloc_addr,
  output logic [TAG_WIDTH-1:0]         alloc_tag,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]       rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic [NUM_RD*TAG_WIDTH-1:0]  rd_tag,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*REG_ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*TAG_WIDTH-1:0]  wr_tag,
  input  logic [NUM_WR*XLEN-1:0]       wr_data
);
  logic [XLEN-1:0]      mem_q [NUM_REGS];
  logic [XLEN-1:0]      mem_d [NUM_REGS];
  logic                 busy_w [NUM_REGS];
  logic [TAG_WIDTH-1:0] tag_w [NUM_REGS];
  logic [TAG_WIDTH-1:0] next_tag_w [NUM_REGS];

  // x0 is hard-wired: never busy, tag 0, and alloc_tag reads as 0.
  assign busy_w[0]     = 1'b0;
  assign tag_w[0]      = '0;
  assign next_tag_w[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    rf_sb_entry #(
      .TAG_WIDTH (TAG_WIDTH),
      .NUM_WR    (NUM_WR),
      .IDX       (rf_addr_t'(i))
    ) u_entry (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_tag     (wr_tag),
      .busy       (busy_w[i]),
      .tag        (tag_w[i]),
      .next_tag   (next_tag_w[i])
    );
  end

  assign alloc_tag = next_tag_w[alloc_addr];

  // Ascending port order lets the highest-index writeback land last and win.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wr_addr[k*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
        mem_d[wr_addr[k*REG_ADDR_W +: REG_ADDR_W]] = wr_data[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_addr_t             ra;
    logic [XLEN-1:0]      val;
    logic                 busy_v;
    logic                 byp_hit;
    logic [TAG_WIDTH-1:0] byp_tag;

    always_comb begin
      ra      = rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
      val     = mem_q[ra];
      busy_v  = busy_w[ra];
      byp_hit = 1'b0;
      byp_tag = '0;
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (ra != '0) && (wr_addr[k*REG_ADDR_W +: REG_ADDR_W] == ra)) begin
            val     = wr_data[k*XLEN +: XLEN];
            byp_hit = 1'b1;
            byp_tag = wr_tag[k*TAG_WIDTH +: TAG_WIDTH];
          end
        end
      end
      if (byp_hit && (byp_tag == tag_w[ra])) begin
        busy_v = 1'b0;
      end
    end

    assign rd_data[p*XLEN +: XLEN]           = rd_en[p] ? val : '0;
    assign rd_busy[p]                        = rd_en[p] & busy_v;
    assign rd_tag[p*TAG_WIDTH +: TAG_WIDTH]  = tag_w[ra];
  end
endmodule

// File: tb/tb_regfile_scoreboard_mp.sv
// Directed vector table plus randomized traffic checked against an array-based scoreboard model.
module tb_regfile_scoreboard_mp;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [1:0]  alloc_tag;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [3:0]  rd_tag;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_tag;
  logic [63:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_mp #(
    .XLEN(32), .TAG_WIDTH(2), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .alloc_tag(alloc_tag), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_tag(wr_tag), .wr_data(wr_data)
  );

  // Reference state: plain arrays indexed by register number.
  logic [31:0] m_data [32];
  bit          m_busy [32];
  int unsigned m_tag  [32];

  typedef struct {
    logic        fl, ae;
    logic [4:0]  aa;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [1:0]  wt0, wt1;
    logic [31:0] wd0, wd1;
    logic [1:0]  e_at;
    logic [31:0] e_d0;
    logic        e_b0;
    logic [1:0]  e_t0;
    logic [31:0] e_d1;
    logic        e_b1;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = 0;
    end
  endtask

  // Compare every combinational output with what the model says for the current inputs.
  task automatic model_check(input string tagname);
    int unsigned a, exp_at;
    logic [31:0] val;
    bit          bsy, hit;
    int unsigned bt;
    a = alloc_addr;
    exp_at = (a == 0) ? 0 : (m_tag[a] + 1) % 4;
    chk($sformatf("%s_alloc_tag", tagname), 32'(alloc_tag), exp_at);
    for (int p = 0; p < 2; p++) begin
      a   = rd_addr[p*5 +: 5];
      val = m_data[a];
      bsy = m_busy[a];
      hit = 1'b0;
      bt  = 0;
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && a != 0 && wr_addr[k*5 +: 5] == a) begin
          val = wr_data[k*32 +: 32];
          hit = 1'b1;
          bt  = wr_tag[k*2 +: 2];
        end
      end
      if (hit && bt == m_tag[a]) bsy = 1'b0;
      if (!rd_en[p]) begin
        val = '0;
        bsy = 1'b0;
      end
      chk($sformatf("%s_rd_data%0d", tagname, p), rd_data[p*32 +: 32], val);
      chk($sformatf("%s_rd_busy%0d", tagname, p), 32'(rd_busy[p]), 32'(bsy));
      chk($sformatf("%s_rd_tag%0d", tagname, p), 32'(rd_tag[p*2 +: 2]), m_tag[a]);
    end
  endtask

  // Apply one clock edge worth of the architectural rules to the model.
  task automatic model_update();
    bit          clr [32];
    int unsigned a;
    for (int i = 0; i < 32; i++) clr[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = wr_addr[k*5 +: 5];
      if (wr_en[k] && a != 0) begin
        m_data[a] = wr_data[k*32 +: 32];
        if (wr_tag[k*2 +: 2] == m_tag[a]) clr[a] = 1'b1;
      end
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) if (clr[i]) m_busy[i] = 1'b0;
      a = alloc_addr;
      if (alloc_en && a != 0) begin
        m_busy[a] = 1'b1;
        m_tag[a]  = (m_tag[a] + 1) % 4;
      end
    end
  endtask

  task automatic drive_idle();
    flush = 0; alloc_en = 0; alloc_addr = 0; rd_en = 0; rd_addr = 0;
    wr_en = 0; wr_addr = 0; wr_tag = 0; wr_data = 0;
  endtask

  task automatic step(input string name);
    #1;
    model_check(name);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    vecs[0]  = '{0,0,5,3,1,0, 0,0,0,0,0,0,0,          1, 0,0,0, 0,0};
    vecs[1]  = '{0,1,5,1,5,0, 0,0,0,0,0,0,0,          1, 0,0,0, 0,0};
    vecs[2]  = '{0,0,5,3,5,5, 0,0,0,0,0,0,0,          2, 0,1,1, 0,1};
    vecs[3]  = '{0,0,5,1,5,5, 1,5,0,1,0,'hDEADBEEF,0, 2, 'hDEADBEEF,0,1, 0,0};
    vecs[4]  = '{0,0,5,3,5,0, 0,0,0,0,0,0,0,          2, 'hDEADBEEF,0,1, 0,0};
    vecs[5]  = '{0,1,5,1,5,0, 0,0,0,0,0,0,0,          2, 'hDEADBEEF,0,1, 0,0};
    vecs[6]  = '{0,1,5,1,5,0, 0,0,0,0,0,0,0,          3, 'hDEADBEEF,1,2, 0,0};
    vecs[7]  = '{0,0,5,1,5,0, 1,5,0,2,0,'h11,0,       0, 'h11,1,3, 0,0};
    vecs[8]  = '{0,0,5,1,5,0, 0,0,0,0,0,0,0,          0, 'h11,1,3, 0,0};
    vecs[9]  = '{0,0,5,1,5,0, 2,0,5,0,3,0,'h22,       0, 'h22,0,3, 0,0};
    vecs[10] = '{0,0,5,1,5,0, 0,0,0,0,0,0,0,          0, 'h22,0,3, 0,0};
    vecs[11] = '{0,0,7,1,7,0, 1,7,0,0,0,'hA5,0,       1, 'hA5,0,0, 0,0};
    vecs[12] = '{0,0,7,3,7,7, 3,7,7,0,0,1,2,          1, 2,0,0, 2,0};
    vecs[13] = '{0,0,7,3,7,7, 0,0,0,0,0,0,0,          1, 2,0,0, 2,0};
    vecs[14] = '{0,1,3,1,3,0, 0,0,0,0,0,0,0,          1, 0,0,0, 0,0};
    vecs[15] = '{0,1,3,1,3,0, 0,0,0,0,0,0,0,          2, 0,1,1, 0,0};
    vecs[16] = '{0,1,3,1,3,0, 0,0,0,0,0,0,0,          3, 0,1,2, 0,0};
    vecs[17] = '{0,1,3,1,3,0, 0,0,0,0,0,0,0,          0, 0,1,3, 0,0};
    vecs[18] = '{1,1,3,1,3,0, 0,0,0,0,0,0,0,          1, 0,1,0, 0,0};
    vecs[19] = '{0,1,0,3,3,0, 1,0,0,0,0,'hFFFFFFFF,0, 0, 0,0,0, 0,0};
    vecs[20] = '{0,0,3,3,0,0, 0,0,0,0,0,0,0,          1, 0,0,0, 0,0};

    model_reset();
    drive_idle();
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      flush = vecs[i].fl; alloc_en = vecs[i].ae; alloc_addr = vecs[i].aa;
      rd_en = vecs[i].re; rd_addr = {vecs[i].ra1, vecs[i].ra0};
      wr_en = vecs[i].we; wr_addr = {vecs[i].wa1, vecs[i].wa0};
      wr_tag = {vecs[i].wt1, vecs[i].wt0}; wr_data = {vecs[i].wd1, vecs[i].wd0};
      #1;
      chk($sformatf("v%0d_alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].e_at));
      chk($sformatf("v%0d_rd_data0", i), rd_data[31:0], vecs[i].e_d0);
      chk($sformatf("v%0d_rd_busy0", i), 32'(rd_busy[0]), 32'(vecs[i].e_b0));
      chk($sformatf("v%0d_rd_tag0", i), 32'(rd_tag[1:0]), 32'(vecs[i].e_t0));
      chk($sformatf("v%0d_rd_data1", i), rd_data[63:32], vecs[i].e_d1);
      chk($sformatf("v%0d_rd_busy1", i), 32'(rd_busy[1]), 32'(vecs[i].e_b1));
      model_check($sformatf("v%0d_model", i));
      @(posedge clk);
      model_update();
      #1;
    end

    // Asynchronous reset in the middle of a cycle with x4 and x9 outstanding.
    drive_idle(); alloc_en = 1; alloc_addr = 4;  step("rst_alloc4");
    drive_idle(); alloc_en = 1; alloc_addr = 9;  step("rst_alloc9");
    drive_idle(); wr_en = 2'b11; wr_addr = {5'd9, 5'd4}; wr_tag = 0;
    wr_data = {32'h99, 32'h44}; step("rst_stale_wb");
    drive_idle(); rd_en = 2'b11; rd_addr = {5'd9, 5'd4}; alloc_addr = 4;
    #1;
    chk("pre_rst_busy", 32'(rd_busy), 32'd3);
    chk("pre_rst_data0", rd_data[31:0], 32'h44);
    chk("pre_rst_tag1", 32'(rd_tag[3:2]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(rd_busy), 32'd0);
    chk("rst_async_data0", rd_data[31:0], 32'd0);
    chk("rst_async_data1", rd_data[63:32], 32'd0);
    chk("rst_async_tag", 32'(rd_tag), 32'd0);
    chk("rst_async_alloc_tag", 32'(alloc_tag), 32'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic over a small address window to force collisions.
    for (int c = 0; c < 400; c++) begin
      int unsigned a;
      flush      = ($urandom_range(0, 15) == 0);
      alloc_en   = $urandom_range(0, 1);
      alloc_addr = 5'($urandom_range(0, 7));
      rd_en      = 2'($urandom);
      rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_en      = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        a = $urandom_range(0, 7);
        wr_addr[k*5 +: 5]   = 5'(a);
        wr_tag[k*2 +: 2]    = ($urandom_range(0, 2) != 0) ? 2'(m_tag[a]) : 2'($urandom);
        wr_data[k*32 +: 32] = $urandom;
      end
      step($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
